irq_request_latch: RTL and testbench

Upstream stage for the 4-input priority encoder. It synchronizes four raw interrupt lines, captures their rising edges into sticky pending bits and presents the masked pending vector on A[4:1] to the encoder. It then takes the encoder's pcode back, registers it as the serviced interrupt ID and holds it under a valid/ack handshake until the consumer acknowledges, which clears that pending bit.

---
 rtl/irq_request_latch_if.sv | 27 ++
 rtl/irq_request_latch.sv | 119 +++++++++++
 tb/tb_irq_request_latch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_request_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_latch_if
// Description : Bundles the latch's request, encoder and grant/ack signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_request_latch_if;
    logic [4:1] irq_in;
    logic [4:1] mask;
    logic [4:1] A;
    logic [2:0] pcode;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [4:1] pending;

    modport master (
        output irq_in, mask, pcode, irq_ack,
        input  A, irq_valid, irq_id, pending
    );

    modport slave (
        input  irq_in, mask, pcode, irq_ack,
        output A, irq_valid, irq_id, pending
    );
endinterface
`default_nettype wire

// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_latch
// Description : Edge-captures 4 IRQ lines into sticky pending bits, presents
//               the masked vector to the encoder and holds a valid/ack grant.
//               Define IRQ_SYNC_EN to insert the two-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_request_latch (
    input  wire logic          clk,
    input  wire logic          rst,
    irq_request_latch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_irq_valid;
    logic [2:0] r_irq_id;
    logic [4:1] r_pending;
    logic [4:1] r_s3;
    logic [4:1] w_line;
    logic [4:1] w_edge;
    logic [4:1] w_clr;
    logic       w_ack_take;
    logic       w_pcode_ok;

`ifdef IRQ_SYNC_EN
    logic [4:1] r_s1;
    logic [4:1] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 4'b0000;
            r_s2 <= 4'b0000;
        end else begin
            r_s1 <= bus.irq_in;
            r_s2 <= r_s1;
        end
    end

    assign w_line = r_s2;
`else
    assign w_line = bus.irq_in;
`endif

    // s3 resets low so a line already high at reset release counts as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3 <= 4'b0000;
        end else begin
            r_s3 <= w_line;
        end
    end

    assign w_edge     = w_line & ~r_s3;
    assign w_ack_take = (r_state == ST_WAIT) && bus.irq_ack;
    assign w_pcode_ok = (bus.pcode != 3'd0) && (bus.pcode <= 3'd4);

    genvar n;
    generate
        for (n = 1; n <= 4; n++) begin : g_clr
            assign w_clr[n] = w_ack_take && (r_irq_id == 3'(n));
        end
    endgenerate

    // OR-ing the edge in last makes a same-cycle set win over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 4'b0000;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_irq_valid <= 1'b0;
            r_irq_id    <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pcode_ok) begin
                        r_irq_id    <= bus.pcode;
                        r_irq_valid <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.irq_ack) begin
                        r_irq_id    <= 3'd0;
                        r_irq_valid <= 1'b0;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_irq_valid <= 1'b0;
                    r_irq_id    <= 3'd0;
                end
            endcase
        end
    end

    assign bus.A         = r_pending & ~bus.mask;
    assign bus.pending   = r_pending;
    assign bus.irq_valid = r_irq_valid;
    assign bus.irq_id    = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_request_latch
// Description : Directed self-checking bench; grants are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic       pc_force_en;
    logic [2:0] pc_force;
    logic       prev_valid;
    logic [2:0] exp_q[$];

    irq_request_latch_if bus ();

    irq_request_latch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference priority encoder: line 4 highest
    function automatic logic [2:0] enc(input logic [4:1] a);
        if (a[4])      return 3'd4;
        else if (a[3]) return 3'd3;
        else if (a[2]) return 3'd2;
        else if (a[1]) return 3'd1;
        else           return 3'd0;
    endfunction

    assign bus.pcode = pc_force_en ? pc_force : enc(bus.A);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input logic [2:0] exp_id);
        for (int i = 0; i < 30 && !bus.irq_valid; i++) tick(1);
        check({tag, "_valid"}, 8'(bus.irq_valid), 8'd1);
        check({tag, "_id"}, 8'(bus.irq_id), 8'(exp_id));
    endtask

    // Scoreboard: every rising irq_valid must match the oldest expected grant
    always @(posedge clk) begin
        #1;
        if (bus.irq_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 8'(exp_q.size()), 8'd1);
            end else begin
                check("sb_grant", 8'(bus.irq_id), 8'(exp_q.pop_front()));
            end
        end
        prev_valid = bus.irq_valid;
    end

    initial begin
        total = 0;
        bad = 0;
        prev_valid = 1'b0;
        pc_force_en = 1'b0;
        pc_force = 3'd0;
        rst = 1'b1;
        bus.irq_in = 4'b0000;
        bus.mask = 4'b0000;
        bus.irq_ack = 1'b0;
        tick(2);
        check("rst_A", 8'(bus.A), 8'h0);
        check("rst_valid", 8'(bus.irq_valid), 8'h0);
        check("rst_id", 8'(bus.irq_id), 8'h0);
        check("rst_pending", 8'(bus.pending), 8'h0);
        rst = 1'b0;

        // Single edge on line 3
        bus.irq_in = 4'b0100;
        exp_q.push_back(3'd3);
        tick(LAT);
        check("single_pend_early", 8'(bus.pending), 8'h0);
        tick(1);
        check("single_pend", 8'(bus.pending), 8'h4);
        check("single_valid_early", 8'(bus.irq_valid), 8'h0);
        tick(1);
        check("single_valid", 8'(bus.irq_valid), 8'h1);
        check("single_id", 8'(bus.irq_id), 8'h3);
        check("single_A", 8'(bus.A), 8'h4);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        bus.irq_in = 4'b0000;
        check("single_ack_valid", 8'(bus.irq_valid), 8'h0);
        check("single_ack_id", 8'(bus.irq_id), 8'h0);
        check("single_ack_pend", 8'(bus.pending), 8'h0);

        // Priority: lines 4 and 1 together
        bus.irq_in = 4'b1001;
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd1);
        wait_valid("prio_first", 3'd4);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check("prio_clr_valid", 8'(bus.irq_valid), 8'h0);
        check("prio_clr_pend", 8'(bus.pending), 8'h1);
        tick(1);
        check("prio_gap_valid", 8'(bus.irq_valid), 8'h0);
        tick(1);
        check("prio_second_valid", 8'(bus.irq_valid), 8'h1);
        check("prio_second_id", 8'(bus.irq_id), 8'h1);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        bus.irq_in = 4'b0000;
        tick(3);
        check("prio_done_pend", 8'(bus.pending), 8'h0);
        check("prio_done_valid", 8'(bus.irq_valid), 8'h0);

        // Masking holds pending but hides it from the encoder
        bus.mask = 4'b0010;
        bus.irq_in = 4'b0010;
        tick(LAT + 3);
        check("mask_pend", 8'(bus.pending), 8'h2);
        check("mask_A", 8'(bus.A), 8'h0);
        check("mask_valid", 8'(bus.irq_valid), 8'h0);
        exp_q.push_back(3'd2);
        bus.mask = 4'b0000;
        #1;
        check("unmask_A", 8'(bus.A), 8'h2);
        wait_valid("unmask", 3'd2);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        bus.irq_in = 4'b0000;
        tick(2);

        // Set-wins: new line-3 edge lands in the ack cycle
        bus.irq_in = 4'b0100;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        wait_valid("setwin_first", 3'd3);
        bus.irq_in = 4'b0000;
        tick(LAT + 1);
        bus.irq_in = 4'b0100;
        tick(LAT);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check("setwin_pend", 8'(bus.pending), 8'h4);
        check("setwin_valid", 8'(bus.irq_valid), 8'h0);
        wait_valid("setwin_regrant", 3'd3);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_in = 4'b0000;
        check("setwin_clr_pend", 8'(bus.pending), 8'h0);

        // Spurious ack in IDLE, then ack held through two grants
        tick(3);
        check("spur_valid", 8'(bus.irq_valid), 8'h0);
        check("spur_pend", 8'(bus.pending), 8'h0);
        bus.irq_in = 4'b0011;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd1);
        tick(LAT + 1);
        check("held_pend", 8'(bus.pending), 8'h3);
        check("held_valid_early", 8'(bus.irq_valid), 8'h0);
        tick(1);
        check("held_g1_id", 8'(bus.irq_id), 8'h2);
        tick(1);
        check("held_c1_valid", 8'(bus.irq_valid), 8'h0);
        check("held_c1_pend", 8'(bus.pending), 8'h1);
        tick(1);
        check("held_gap_valid", 8'(bus.irq_valid), 8'h0);
        tick(1);
        check("held_g2_id", 8'(bus.irq_id), 8'h1);
        tick(1);
        check("held_c2_valid", 8'(bus.irq_valid), 8'h0);
        check("held_c2_pend", 8'(bus.pending), 8'h0);
        bus.irq_ack = 1'b0;
        bus.irq_in = 4'b0000;

        // Illegal pcode in IDLE is ignored
        pc_force_en = 1'b1;
        pc_force = 3'd6;
        tick(3);
        check("illegal_valid", 8'(bus.irq_valid), 8'h0);
        check("illegal_id", 8'(bus.irq_id), 8'h0);
        pc_force_en = 1'b0;

        // Reset mid-grant, lines still high after release
        bus.irq_in = 4'b1001;
        exp_q.push_back(3'd4);
        wait_valid("rstmid_first", 3'd4);
        check("rstmid_pend", 8'(bus.pending), 8'h9);
        rst = 1'b1;
        tick(1);
        check("rstmid_valid", 8'(bus.irq_valid), 8'h0);
        check("rstmid_id", 8'(bus.irq_id), 8'h0);
        check("rstmid_pend0", 8'(bus.pending), 8'h0);
        check("rstmid_A", 8'(bus.A), 8'h0);
        rst = 1'b0;
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd1);
        wait_valid("rstmid_regrant", 3'd4);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check("rstmid_pend_after", 8'(bus.pending), 8'h1);
        wait_valid("rstmid_second", 3'd1);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        bus.irq_in = 4'b0000;
        tick(4);
        check("end_pend", 8'(bus.pending), 8'h0);
        check("sb_leftover", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
